// File: rtl/ftransform_mb_sched_pkg.sv
// Shared types and constants for the macroblock FTransform scheduler.
package ftransform_mb_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BLK_IDX_W   = 5;
    localparam int LUMA_BLKS   = 16;
    localparam int CHROMA_BLKS = 8;

    function automatic logic [BLK_IDX_W-1:0] last_blk_idx(input logic chroma);
        return chroma ? BLK_IDX_W'(CHROMA_BLKS - 1) : BLK_IDX_W'(LUMA_BLKS - 1);
    endfunction

endpackage

// File: rtl/ftsched_skid_fifo.sv
// First-word-fall-through skid FIFO: a push into an empty FIFO is visible at the head
// in the same cycle and may be consumed without ever being stored.
module ftsched_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty;
    logic             bypass;
    logic             store;
    logic             pop_stored;

    always_comb begin
        empty      = (count_q == '0);
        bypass     = empty && push_i && ready_i;
        store      = push_i && !bypass;
        pop_stored = !empty && ready_i;
        valid_o    = !empty || push_i;
        data_o     = '0;
        if (!empty) begin
            data_o = mem_q[rd_ptr_q];
        end else if (push_i) begin
            data_o = push_data_i;
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(store);
        rd_ptr_d = rd_ptr_q + AW'(pop_stored);
        count_d  = count_q + CW'(store) - CW'(pop_stored);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ftransform_mb_sched.sv
// Issues the 16 luma / 8 chroma 4x4 blocks of a macroblock through one FTransform,
// credit-gated into a skid FIFO. FTSCHED_NZ_MASK_EN adds the nz_mask_o output.
module ftransform_mb_sched
    import ftransform_mb_sched_pkg::*;
#(
    parameter int O_WIDTH  = 12,
    parameter int FT_LAT   = 2,
    parameter int FIFO_DEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  chroma_i,
    output logic                  busy_o,
    output logic                  mb_done_o,
`ifdef FTSCHED_NZ_MASK_EN
    output logic [15:0]           nz_mask_o,
`endif
    output logic                  ft_start_o,
    output logic [BLK_IDX_W-1:0]  ft_blk_idx_o,
    input  logic                  ft_done_i,
    input  logic [16*O_WIDTH-1:0] ft_out_i,
    output logic                  coeff_valid_o,
    input  logic                  coeff_ready_i,
    output logic [16*O_WIDTH-1:0] coeff_data_o,
    output logic [BLK_IDX_W-1:0]  coeff_idx_o,
    output logic                  coeff_last_o
);

    localparam int DATA_W = 16 * O_WIDTH;
    localparam int ENT_W  = DATA_W + BLK_IDX_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEP) + 1;
    localparam int SUM_W  = 8;

    state_e               state_q, state_d;
    logic                 chroma_q, chroma_d;
    logic [BLK_IDX_W-1:0] blk_q, blk_d;
    logic                 issue_last;

    logic                 trk_valid_q [FT_LAT];
    logic                 trk_valid_d [FT_LAT];
    logic [BLK_IDX_W-1:0] trk_idx_q   [FT_LAT];
    logic [BLK_IDX_W-1:0] trk_idx_d   [FT_LAT];
    logic                 trk_last_q  [FT_LAT];
    logic                 trk_last_d  [FT_LAT];

    logic [SUM_W-1:0]     inflight;
    logic [SUM_W-1:0]     credit_sum;
    logic                 credit_ok;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    logic [ENT_W-1:0]     push_data;
    logic [ENT_W-1:0]     head_data;

    assign issue_last = (blk_q == last_blk_idx(chroma_q));

    // In-flight tracker mirrors the FTransform pipeline so each done has its tag.
    genvar gi;
    generate
        for (gi = 0; gi < FT_LAT; gi++) begin : g_trk
            if (gi == 0) begin : g_head
                assign trk_valid_d[gi] = ft_start_o;
                assign trk_idx_d[gi]   = blk_q;
                assign trk_last_d[gi]  = issue_last;
            end else begin : g_tail
                assign trk_valid_d[gi] = trk_valid_q[gi-1];
                assign trk_idx_d[gi]   = trk_idx_q[gi-1];
                assign trk_last_d[gi]  = trk_last_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FT_LAT; i++) begin
                trk_valid_q[i] <= 1'b0;
                trk_idx_q[i]   <= '0;
                trk_last_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < FT_LAT; i++) begin
                trk_valid_q[i] <= trk_valid_d[i];
                trk_idx_q[i]   <= trk_idx_d[i];
                trk_last_q[i]  <= trk_last_d[i];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < FT_LAT; i++) begin
            inflight = inflight + SUM_W'(trk_valid_q[i]);
        end
    end

    // A block is only issued if a FIFO slot is guaranteed when its done arrives.
    assign credit_sum = inflight + SUM_W'(fifo_count);
    assign credit_ok  = credit_sum < SUM_W'(FIFO_DEP);

    assign push      = ft_done_i && trk_valid_q[FT_LAT-1];
    assign push_data = {ft_out_i, trk_idx_q[FT_LAT-1], trk_last_q[FT_LAT-1]};

    ftsched_skid_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEP)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .ready_i     (coeff_ready_i),
        .valid_o     (coeff_valid_o),
        .data_o      (head_data),
        .count_o     (fifo_count)
    );

    assign {coeff_data_o, coeff_idx_o, coeff_last_o} = head_data;
    assign pop = coeff_valid_o && coeff_ready_i;

    always_comb begin
        state_d    = state_q;
        chroma_d   = chroma_q;
        blk_d      = blk_q;
        ft_start_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_ISSUE;
                    chroma_d = chroma_i;
                    blk_d    = '0;
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    ft_start_o = 1'b1;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && coeff_last_o) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                blk_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            chroma_q <= 1'b0;
            blk_q    <= '0;
        end else begin
            state_q  <= state_d;
            chroma_q <= chroma_d;
            blk_q    <= blk_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign mb_done_o    = (state_q == ST_DONE);
    assign ft_blk_idx_o = blk_q;

`ifdef FTSCHED_NZ_MASK_EN
    logic [15:0] nz_mask_q, nz_mask_d;

    always_comb begin
        nz_mask_d = nz_mask_q;
        if (state_q == ST_IDLE && start_i) begin
            nz_mask_d = '0;
        end else if (pop && (|coeff_data_o)) begin
            nz_mask_d[coeff_idx_o[3:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_mask_q <= '0;
        end else begin
            nz_mask_q <= nz_mask_d;
        end
    end

    assign nz_mask_o = nz_mask_q;
`endif

    unmatched_done_a: assert property (@(posedge clk) disable iff (!rst_n)
        ft_done_i |-> trk_valid_q[FT_LAT-1]);

    credit_a: assert property (@(posedge clk) disable iff (!rst_n)
        credit_sum <= SUM_W'(FIFO_DEP));

endmodule
